pipeline_hazard_controller: RTL
===============================

// Module: pipeline_hazard_controller
// PURPOSE
//  Stall/flush/forwarding sequencer for the 5-stage pipelined MIPS core (IF_ID, ID_EX, EX_MEM, MEM_WB).
//  Detects RAW and load-use hazards, squashes wrong-path instructions on jump/jr/branch, and adds a
//  debug halt/single-step FSM that drains the pipeline. Drives PC_Register enable and PLRegister enable/flush.
// PARAMETERS
//  DRAIN_CYCLES  4   cycles needed to retire every in-flight instruction after fetch stops
//  CNT_WIDTH     16  width of saturating stall-cycle counter
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   asynchronous, active-high reset
//  id_rs, id_rt    in   5   IF_ID instruction [25:21], [20:16]
//  id_uses_rs/rt   in   1   ID instruction reads rs / rt
//  id_jump         in   1   Control Jump for IF_ID instruction
//  ex_rs, ex_rt    in   5   ID_EX source regs
//  ex_write_reg    in   5   ID_EX destination (after RegDst mux)
//  ex_reg_write    in   1   ID_EX RegWrite
//  ex_mem_read     in   1   ID_EX MemRead
//  ex_jr           in   1   jr resolved in EX
//  mem_write_reg   in   5   EX_MEM write register
//  mem_reg_write   in   1   EX_MEM RegWrite
//  mem_branch_taken in  1   EX_MEM BranchEQ_NE & Zero
//  wb_write_reg    in   5   MEM_WB write register
//  wb_reg_write    in   1   MEM_WB RegWrite
//  halt_req        in   1   level: debug halt request
//  step_req        in   1   pulse: release one instruction while halted
//  pc_enable       out  1   PC load enable
//  if_id_enable    out  1   IF_ID enable
//  if_id_flush     out  1   IF_ID synchronous clear (bubble)
//  id_ex_flush     out  1   ID_EX clear
//  ex_mem_flush    out  1   EX_MEM clear
//  forward_a/b     out  2   ALU operand source select (FWD_* encodings)
//  halted          out  1   pipeline empty and frozen
//  stall_count     out  CNT_WIDTH  stall cycles since reset, saturating
// BEHAVIOUR
//  - Reset: state RUN, drain_cnt 0, stall_count 0; outputs pc_enable=1, if_id_enable=1, flushes 0,
//    forward 00, halted 0. Hazard outputs masked while reset asserted. Reset mid-DRAIN/STEP -> RUN.
//  - Hazard/flush outputs combinational from state + inputs (zero latency); state/counters registered.
//  - Register $0 never matches any hazard or forwarding compare.
//  - Priority per cycle: mem_branch_taken > ex_jr > id_jump > stall > halt sequencing.
//    branch: pc_enable=1, flush IF_ID, ID_EX, EX_MEM; any stall that cycle dropped.
//    jr: pc_enable=1, flush IF_ID, ID_EX.  jump: pc_enable=1, flush IF_ID.
//  - Stall: pc_enable=0, if_id_enable=0, id_ex_flush=1; stall_count += 1 (saturates at all-ones).
//  - States RUN, DRAIN, HALTED, STEP:
//    RUN: halt_req=1 and no stall/flush this cycle -> DRAIN, drain_cnt=DRAIN_CYCLES.
//    DRAIN: pc_enable=0 and if_id_flush=1 unless redirect; drain_cnt decrements on non-stall cycles;
//      at 1 -> HALTED. Redirect during DRAIN loads PC, does not reload drain_cnt.
//    HALTED: halted=1, pc_enable=0, if_id_flush=1. halt_req=0 -> RUN; step_req=1 -> STEP.
//      step_req ignored outside HALTED; halt_req wins over step_req if both change together... (halt_req=0 -> RUN).
//    STEP: one cycle pc_enable=1, if_id_enable=1, no flush -> DRAIN, drain_cnt=DRAIN_CYCLES.
//    Stall in STEP holds STEP until fetch completes.
// CONFIGURATION
//  FORWARDING_EN defined: forward_a/b = FWD_EX_MEM if mem_reg_write & mem_write_reg==ex_rs/rt,
//    else FWD_MEM_WB if wb match, else FWD_REG; stall only on load-use
//    (ex_mem_read & ex_write_reg matches used id_rs/id_rt) for exactly 1 cycle.
//  Undefined: forward_a/b tied 00; stall while any used ID source matches a writing ex/mem/wb
//    destination (up to 3 consecutive cycles).
// STRUCTURE
//  Shared package mips_pipeline_pkg: state enum (RUN/DRAIN/HALTED/STEP), FWD_REG=2'b00,
//  FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10, REG_ZERO=5'd0.
//  Sub-module forwarding_unit (combinational compares, instantiated only under FORWARDING_EN).
// TESTING
//  1 ex_mem_read=1, ex_write_reg=8, id_rs=8 uses_rs -> 1 cycle pc_enable=0, id_ex_flush=1, stall_count=1;
//    next cycle (wb_write_reg=8) forward_a=01.
//  2 FORWARDING_EN: mem_write_reg=9 reg_write, ex_rs=9 -> forward_a=10, no stall; undefined: id_rs=9
//    vs ex_write_reg=9 -> 3 stall cycles.
//  3 mem_branch_taken=1 with simultaneous load-use -> 3 flushes, pc_enable=1, stall_count unchanged.
//  4 halt_req=1 in quiet RUN -> pc_enable=0 for 4 cycles, halted=1 on 5th, PC value unchanged.
//  5 step_req pulse in HALTED -> pc_enable=1 one cycle, halted=0 for 5 cycles, then 1.
//  6 reset asserted mid-DRAIN -> immediately RUN outputs, halted=0, stall_count=0.

Source files
------------

// File: rtl/mips_pipeline_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// Holds the sequencer state enum, forwarding-select encodings and the register compare helper.
package mips_pipeline_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } state_t;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    localparam logic [4:0] REG_ZERO   = 5'd0;

    // $0 is hardwired, so a write to it never produces a dependency.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst, input logic wr);
        return wr && (dst != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// ALU operand bypass select: the youngest writer (EX_MEM) wins over MEM_WB.
// Instantiated by pipeline_hazard_controller only when FORWARDING_EN is defined.
module forwarding_unit
    import mips_pipeline_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_write_reg,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_write_reg,
    input  logic       wb_reg_write,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] mem_dst,
                                           input logic mem_wr, input logic [4:0] wb_dst,
                                           input logic wb_wr);
        if (reg_hit(src, mem_dst, mem_wr))
            return FWD_EX_MEM;
        else if (reg_hit(src, wb_dst, wb_wr))
            return FWD_MEM_WB;
        else
            return FWD_REG;
    endfunction

    assign forward_a = fwd_sel(ex_rs, mem_write_reg, mem_reg_write, wb_write_reg, wb_reg_write);
    assign forward_b = fwd_sel(ex_rt, mem_write_reg, mem_reg_write, wb_write_reg, wb_reg_write);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forwarding sequencer with debug halt/single-step drain FSM for the 5-stage MIPS core.
// Define FORWARDING_EN to enable operand bypassing (stall only on load-use); otherwise stall on any RAW.
module pipeline_hazard_controller
    import mips_pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 id_jump,
    input  logic [4:0]           ex_rs,
    input  logic [4:0]           ex_rt,
    input  logic [4:0]           ex_write_reg,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_read,
    input  logic                 ex_jr,
    input  logic [4:0]           mem_write_reg,
    input  logic                 mem_reg_write,
    input  logic                 mem_branch_taken,
    input  logic [4:0]           wb_write_reg,
    input  logic                 wb_reg_write,
    input  logic                 halt_req,
    input  logic                 step_req,
    output logic                 pc_enable,
    output logic                 if_id_enable,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic [1:0]           forward_a,
    output logic [1:0]           forward_b,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic [1:0]    fwd_a, fwd_b;
    logic          stall_req, redirect, stall;

`ifdef FORWARDING_EN
    forwarding_unit u_fwd (
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .mem_write_reg (mem_write_reg),
        .mem_reg_write (mem_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_reg_write  (wb_reg_write),
        .forward_a     (fwd_a),
        .forward_b     (fwd_b)
    );

    // Loaded data only exists after MEM, so a consumer directly behind a load waits one cycle.
    assign stall_req = ex_mem_read &&
                       ((id_uses_rs && reg_hit(id_rs, ex_write_reg, 1'b1)) ||
                        (id_uses_rt && reg_hit(id_rt, ex_write_reg, 1'b1)));

    logic unused_fwd;
    assign unused_fwd = ex_reg_write;
`else
    logic rs_busy, rt_busy;

    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;

    // Without bypassing, hold ID until the producer has left WB.
    assign rs_busy = reg_hit(id_rs, ex_write_reg, ex_reg_write) ||
                     reg_hit(id_rs, mem_write_reg, mem_reg_write) ||
                     reg_hit(id_rs, wb_write_reg, wb_reg_write);
    assign rt_busy = reg_hit(id_rt, ex_write_reg, ex_reg_write) ||
                     reg_hit(id_rt, mem_write_reg, mem_reg_write) ||
                     reg_hit(id_rt, wb_write_reg, wb_reg_write);
    assign stall_req = (id_uses_rs && rs_busy) || (id_uses_rt && rt_busy);

    logic unused_src;
    assign unused_src = ^{ex_rs, ex_rt, ex_mem_read};
`endif

    assign redirect = mem_branch_taken || ex_jr || id_jump;
    assign stall    = stall_req && !redirect;

    always_comb begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        forward_a    = FWD_REG;
        forward_b    = FWD_REG;
        halted       = 1'b0;
        if (!reset) begin
            forward_a = fwd_a;
            forward_b = fwd_b;
            halted    = (state == HALTED);
            if (mem_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (ex_jr) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (id_jump) begin
                if_id_flush = 1'b1;
            end else if (stall) begin
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                id_ex_flush  = 1'b1;
            end else if (state == DRAIN || state == HALTED) begin
                pc_enable   = 1'b0;
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= '0;
            stall_count <= '0;
        end else begin
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            case (state)
                RUN: if (halt_req && !stall && !redirect) begin
                    state     <= DRAIN;
                    drain_cnt <= DW'(DRAIN_CYCLES);
                end
                DRAIN: if (!stall) begin
                    if (drain_cnt <= DW'(1)) begin
                        state     <= HALTED;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt_req)
                        state <= RUN;
                    else if (step_req)
                        state <= STEP;
                end
                STEP: if (!stall) begin
                    state     <= DRAIN;
                    drain_cnt <= DW'(DRAIN_CYCLES);
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
